vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream raster-timing stage for every sprite/overlay renderer in the display path: the board renderer, piece sprites and side-to-move banners.
- Generates the pixel coordinates DrawX/DrawY, a visible-area flag `blank`, and active-low VGA sync for 640x480@60 on the 25 MHz `vga_clk`.
- Also outputs sync/blank copies delayed by PIPE_DELAY cycles. These align with renderers that register colour one cycle after the coordinates (ROM read on negedge, pixel on posedge).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, delay of hs_d/vs_d/blank_d in clocks; legal range 0..4

Ports:
- vga_clk  in  1  pixel clock (25 MHz); only clock
- reset  in  1  synchronous, active-high
- DrawX  out  10  horizontal counter (0..H_TOTAL-1)
- DrawY  out  10  vertical counter (0..V_TOTAL-1)
- blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE)
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse at DrawX==0, DrawY==0
- line_end  out  1  one-cycle pulse at DrawX==H_TOTAL-1
- hs_d  out  1  hs delayed PIPE_DELAY clocks (drives VGA/HDMI encoder)
- vs_d  out  1  vs delayed PIPE_DELAY clocks
- blank_d  out  1  blank delayed PIPE_DELAY clocks

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Counters:
  - hc and vc are registered, 10 bits. DrawX=hc and DrawY=vc are driven directly from the registers.
  - Every clock hc increments. At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - When hc==H_TOTAL-1 and vc==V_TOTAL-1, both wrap to 0 on the same edge.
- Decodes are combinational from hc/vc, so they have zero latency relative to DrawX/DrawY:
  - hs=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blank=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
  - frame_start=1 iff hc==0 and vc==0. line_end=1 iff hc==H_TOTAL-1.
- Delay line:
  - A PIPE_DELAY-stage shift register carries {hs,vs,blank}.
  - PIPE_DELAY==0: the _d outputs are wired to the undelayed signals.
  - Otherwise the _d outputs equal the undelayed values from exactly PIPE_DELAY clocks earlier.
- Reset:
  - On a clock edge with reset=1: hc=0, vc=0, and every delay stage loads idle {hs=1, vs=1, blank=0}.
  - During reset the undelayed outputs therefore read DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1.
  - While reset is held, the _d outputs are 1/1/0.
  - Reset asserted mid-frame aborts the frame. The first cycle after deassertion is DrawX=0, DrawY=0 with frame_start=1, i.e. a clean new frame.
  - No partial sync pulse may be stretched by reset: hs_d/vs_d go high on the edge where reset is sampled.
- The counters never exceed H_TOTAL-1 / V_TOTAL-1. Out-of-range states must not occur; if forced, the next wrap rule still returns them to 0.
- Frame period is exactly H_TOTAL*V_TOTAL = 420000 clocks.

Decomposition:
- Package vga_pkg:
  - VGA_COORD_W=10
  - 640x480 timing constants (H_VISIBLE..V_BP, H_TOTAL, V_TOTAL)
  - typedef vga_coord_t (logic [9:0])
  - typedef vga_ctrl_t (struct: hs, vs, blank)
- Sub-module sync_delay_line: parameterised depth, carries vga_ctrl_t, synchronous reset to idle, pass-through when depth 0.

Test Plan:
- Reset held 3 clocks, then released -> DrawX=0, DrawY=0, frame_start=1 on the first cycle; DrawX=1 on the next.
- Run one line from DrawY=0 -> blank=1 for DrawX 0..639, 0 at 640; hs=0 exactly for DrawX 656..751 (96 clocks); line_end at DrawX=799; DrawY becomes 1 with DrawX=0.
- Run a full frame -> vs=0 exactly for DrawY 490..491 (1600 clocks); blank=0 for all of DrawY 480..524; next frame_start 420000 clocks after the previous one.
- PIPE_DELAY=1 -> hs_d falls on the clock after DrawX=656 (hs falls at 656); blank_d falls one clock after DrawX=640.
- PIPE_DELAY=0 -> hs_d==hs, vs_d==vs, blank_d==blank on every cycle.
- Assert reset at DrawX=700, DrawY=490 (hs and vs both low) -> on that edge hs_d=1, vs_d=1, blank_d=0; after release, counting restarts at 0,0 with no stale delayed values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and control-bus types.
package vga_pkg;

  localparam int unsigned VGA_COORD_W = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [VGA_COORD_W-1:0] vga_coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_ctrl_t;

  // Syncs deasserted, nothing visible.
  localparam vga_ctrl_t VGA_CTRL_IDLE = 3'b110;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for the sync/blank control bundle; depth 0 is a wire.
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  vga_ctrl_t ctrl,
  output vga_ctrl_t ctrl_delayed
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign ctrl_delayed = ctrl;
    end else begin : g_pipe
      vga_ctrl_t stage [DEPTH];

      // Reset forces every stage idle so no partial sync pulse survives reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= VGA_CTRL_IDLE;
        end else begin
          stage[0] <= ctrl;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign ctrl_delayed = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter for VGA timing: coordinates, blank, syncs and a delayed sync/blank copy.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FP       = vga_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_pkg::H_BP,
  parameter int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FP       = vga_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_pkg::V_BP,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic                           vga_clk,
  input  logic                           reset,
  output logic [vga_pkg::VGA_COORD_W-1:0] DrawX,
  output logic [vga_pkg::VGA_COORD_W-1:0] DrawY,
  output logic                           blank,
  output logic                           hs,
  output logic                           vs,
  output logic                           frame_start,
  output logic                           line_end,
  output logic                           hs_d,
  output logic                           vs_d,
  output logic                           blank_d
);

  localparam int unsigned W        = vga_pkg::VGA_COORD_W;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [W-1:0] hc;
  logic [W-1:0] vc;
  logic         h_wrap;
  logic         v_wrap;

  // >= rather than == so a corrupted count still wraps back to zero.
  assign h_wrap = (hc >= W'(H_TOTAL - 1));
  assign v_wrap = (vc >= W'(V_TOTAL - 1));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      vc <= v_wrap ? '0 : vc + W'(1);
    end else begin
      hc <= hc + W'(1);
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = (hc < W'(H_VISIBLE)) && (vc < W'(V_VISIBLE));
  assign hs          = !((hc >= W'(HS_START)) && (hc < W'(HS_END)));
  assign vs          = !((vc >= W'(VS_START)) && (vc < W'(VS_END)));
  assign frame_start = (hc == '0) && (vc == '0);
  assign line_end    = (hc == W'(H_TOTAL - 1));

  vga_pkg::vga_ctrl_t ctrl_now;
  vga_pkg::vga_ctrl_t ctrl_late;

  assign ctrl_now.hs    = hs;
  assign ctrl_now.vs    = vs;
  assign ctrl_now.blank = blank;

  sync_delay_line #(
    .DEPTH(PIPE_DELAY)
  ) u_delay (
    .clk          (vga_clk),
    .reset        (reset),
    .ctrl         (ctrl_now),
    .ctrl_delayed (ctrl_late)
  );

  assign hs_d    = ctrl_late.hs;
  assign vs_d    = ctrl_late.vs;
  assign blank_d = ctrl_late.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen: full-size timing at delay 1 and 0, scaled timing at delay 2.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  // Full-size, PIPE_DELAY=1
  logic [9:0] dx_1, dy_1;
  logic bl_1, hs_1, vs_1, fs_1, le_1, hsd_1, vsd_1, bld_1;
  // Full-size, PIPE_DELAY=0
  logic [9:0] dx_0, dy_0;
  logic bl_0, hs_0, vs_0, fs_0, le_0, hsd_0, vsd_0, bld_0;
  // Scaled 16x12 raster, PIPE_DELAY=2
  logic [9:0] dx_s, dy_s;
  logic bl_s, hs_s, vs_s, fs_s, le_s, hsd_s, vsd_s, bld_s;

  vga_timing_gen u1 (
    .vga_clk(clk), .reset(reset), .DrawX(dx_1), .DrawY(dy_1), .blank(bl_1),
    .hs(hs_1), .vs(vs_1), .frame_start(fs_1), .line_end(le_1),
    .hs_d(hsd_1), .vs_d(vsd_1), .blank_d(bld_1)
  );

  vga_timing_gen #(.PIPE_DELAY(0)) u0 (
    .vga_clk(clk), .reset(reset), .DrawX(dx_0), .DrawY(dy_0), .blank(bl_0),
    .hs(hs_0), .vs(vs_0), .frame_start(fs_0), .line_end(le_0),
    .hs_d(hsd_0), .vs_d(vsd_0), .blank_d(bld_0)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIPE_DELAY(2)
  ) us (
    .vga_clk(clk), .reset(reset), .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s),
    .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .line_end(le_s),
    .hs_d(hsd_s), .vs_d(vsd_s), .blank_d(bld_s)
  );

  int vectors;
  int miscompares;

  // Reference raster state
  int mx, my, sx, sy;
  logic [2:0] m_d1;
  logic [2:0] s_st1, s_st2;

  // {hs, vs, blank} for a coordinate under the given timing.
  function automatic logic [2:0] ctrl_of(int x, int y, int hv, int hf, int hsy,
                                         int vv, int vf, int vsy);
    logic h, v, b;
    h = !(x >= hv + hf && x < hv + hf + hsy);
    v = !(y >= vv + vf && y < vv + vf + vsy);
    b = (x < hv) && (y < vv);
    return {h, v, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mx = 0; my = 0; m_d1 = 3'b110;
      sx = 0; sy = 0; s_st1 = 3'b110; s_st2 = 3'b110;
    end else begin
      m_d1  = ctrl_of(mx, my, 640, 16, 96, 480, 10, 2);
      s_st2 = s_st1;
      s_st1 = ctrl_of(sx, sy, 8, 2, 3, 6, 2, 2);
      if (mx == 799) begin mx = 0; my = (my == 524) ? 0 : my + 1; end
      else mx++;
      if (sx == 15) begin sx = 0; sy = (sy == 11) ? 0 : sy + 1; end
      else sx++;
    end
    #1;
  endtask

  task automatic check_all();
    logic [2:0] c, s;
    c = ctrl_of(mx, my, 640, 16, 96, 480, 10, 2);
    s = ctrl_of(sx, sy, 8, 2, 3, 6, 2, 2);
    chk("dx1", 32'(dx_1), mx);
    chk("dy1", 32'(dy_1), my);
    chk("blank1", 32'(bl_1), 32'(c[0]));
    chk("hs1", 32'(hs_1), 32'(c[2]));
    chk("vs1", 32'(vs_1), 32'(c[1]));
    chk("fs1", 32'(fs_1), 32'(mx == 0 && my == 0));
    chk("le1", 32'(le_1), 32'(mx == 799));
    chk("hsd1", 32'(hsd_1), 32'(m_d1[2]));
    chk("vsd1", 32'(vsd_1), 32'(m_d1[1]));
    chk("bld1", 32'(bld_1), 32'(m_d1[0]));
    chk("dx0", 32'(dx_0), mx);
    chk("hsd0", 32'(hsd_0), 32'(c[2]));
    chk("vsd0", 32'(vsd_0), 32'(c[1]));
    chk("bld0", 32'(bld_0), 32'(c[0]));
    chk("dxs", 32'(dx_s), sx);
    chk("dys", 32'(dy_s), sy);
    chk("blanks", 32'(bl_s), 32'(s[0]));
    chk("hss", 32'(hs_s), 32'(s[2]));
    chk("vss", 32'(vs_s), 32'(s[1]));
    chk("fss", 32'(fs_s), 32'(sx == 0 && sy == 0));
    chk("les", 32'(le_s), 32'(sx == 15));
    chk("hsds", 32'(hsd_s), 32'(s_st2[2]));
    chk("vsds", 32'(vsd_s), 32'(s_st2[1]));
    chk("blds", 32'(bld_s), 32'(s_st2[0]));
  endtask

  initial begin
    int hs_low, vs_low_s, le_pos, blank_fall, hsd_fall, cyc, last_fs;
    vectors = 0; miscompares = 0;
    mx = 0; my = 0; sx = 0; sy = 0;
    m_d1 = 3'b110; s_st1 = 3'b110; s_st2 = 3'b110;
    reset = 1'b1;

    // Reset held three clocks
    repeat (3) tick();
    check_all();
    chk("rst_dx", 32'(dx_1), 0);
    chk("rst_fs", 32'(fs_1), 1);
    chk("rst_hs", 32'(hs_1), 1);
    chk("rst_hsd", 32'(hsd_1), 1);
    chk("rst_vsd", 32'(vsd_1), 1);
    chk("rst_bld", 32'(bld_1), 0);

    // First cycles after release
    reset = 1'b0;
    check_all();
    chk("first_dx", 32'(dx_1), 0);
    chk("first_fs", 32'(fs_1), 1);
    tick();
    check_all();
    chk("second_dx", 32'(dx_1), 1);
    chk("second_fs", 32'(fs_1), 0);

    // Remainder of line 0 on the full raster, four scaled frames alongside
    hs_low = 0; vs_low_s = 0; le_pos = -1; blank_fall = -1; hsd_fall = -1;
    cyc = 1; last_fs = 0;
    for (int i = 0; i < 799; i++) begin
      check_all();
      if (!hs_1) hs_low++;
      if (le_1) le_pos = 32'(dx_1);
      if (!bl_1 && blank_fall < 0) blank_fall = 32'(dx_1);
      if (!hsd_1 && hsd_fall < 0) hsd_fall = 32'(dx_1);
      if (i < 768 && !vs_s) vs_low_s++;
      if (fs_s) begin
        chk("s_frame_period", cyc - last_fs, 192);
        last_fs = cyc;
      end
      tick();
      cyc++;
    end
    check_all();
    chk("hs_low_count", hs_low, 96);
    chk("line_end_pos", le_pos, 799);
    chk("blank_fall_pos", blank_fall, 640);
    chk("hsd_fall_pos", hsd_fall, 657);
    chk("s_vs_low_count", vs_low_s, 128);
    chk("line1_dx", 32'(dx_1), 0);
    chk("line1_dy", 32'(dy_1), 1);

    // Advance into the hsync of line 1, then reset mid-pulse
    repeat (700) begin tick(); check_all(); end
    chk("pre_rst_dx", 32'(dx_1), 700);
    chk("pre_rst_hs", 32'(hs_1), 0);
    chk("pre_rst_hsd", 32'(hsd_1), 0);
    reset = 1'b1;
    tick();
    check_all();
    chk("rst_edge_hsd", 32'(hsd_1), 1);
    chk("rst_edge_vsd", 32'(vsd_1), 1);
    chk("rst_edge_bld", 32'(bld_1), 0);
    chk("rst_edge_dx", 32'(dx_1), 0);
    tick();
    reset = 1'b0;
    check_all();
    chk("restart_fs", 32'(fs_1), 1);
    tick();
    check_all();
    chk("restart_bld", 32'(bld_1), 1);

    // Scaled raster: reach x=12,y=8 where hs, vs and their delayed copies are all low
    repeat (139) begin tick(); check_all(); end
    chk("s_pre_dx", 32'(dx_s), 12);
    chk("s_pre_dy", 32'(dy_s), 8);
    chk("s_pre_hsd", 32'(hsd_s), 0);
    chk("s_pre_vsd", 32'(vsd_s), 0);
    reset = 1'b1;
    tick();
    check_all();
    chk("s_rst_hsd", 32'(hsd_s), 1);
    chk("s_rst_vsd", 32'(vsd_s), 1);
    chk("s_rst_bld", 32'(bld_s), 0);
    tick();
    reset = 1'b0;
    check_all();
    repeat (4) begin tick(); check_all(); end
    chk("s_post_dx", 32'(dx_s), 4);
    chk("s_post_bld", 32'(bld_s), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
